bn_range_stat: RTL

Streaming statistics stage of the range batch-normalization datapath. It sits directly downstream of the 3-to-1 operand multiplexer and consumes the selected 16-bit sample stream. Over one batch of 2^BATCH_LOG2 samples it accumulates the sum, maximum and minimum. It then presents the batch mean and range (max − min) to the normalization stage through a valid/ready handshake.

---
 rtl/bn_range_stat.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bn_range_stat.sv
// ============================================================================
// bn_range_stat
// ----------------------------------------------------------------------------
// Streaming statistics stage of the range batch-normalization datapath.
// Consumes the selected signed sample stream from the operand mux. Over one
// batch of 2**BATCH_LOG2 samples it accumulates the sum, maximum and minimum.
// It then presents the batch mean and range (max - min) downstream through a
// valid/ready handshake.
//
// Parameters:
//   DATA_WIDTH  sample width, two's-complement signed (default 16)
//   BATCH_LOG2  log2 of samples per batch, legal 1..8 (default 5)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      one-cycle pulse: clear statistics and begin a batch
//   in_valid   in_data carries a sample
//   in_data    signed sample
//   in_ready   block accepts a sample this cycle (high in ACCUM)
//   out_valid  mean and range are valid (high in DONE)
//   out_ready  downstream accepts the result
//   mean       signed batch mean
//   range      unsigned max - min, one bit wider than a sample
//   busy       high in ACCUM or DONE
//
// Build option:
//   BN_STAT_ROUND_EN  when defined, mean rounds half toward +inf instead of
//                     flooring. Range, handshake and timing are unaffected.
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; no samples consumed, no result offered
//   ACCUM   | accepting samples, updating sum/max/min/count
//   DONE    | result registered and offered; waits for out_ready
// ============================================================================
module bn_range_stat #(
    parameter int DATA_WIDTH = 16,
    parameter int BATCH_LOG2 = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] mean,
    output logic        [DATA_WIDTH:0]   range,
    output logic                         busy
);

    // A full batch of extreme samples needs exactly BATCH_LOG2 extra bits,
    // so the accumulator can never overflow.
    localparam int ACC_W = DATA_WIDTH + BATCH_LOG2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic signed [DATA_WIDTH-1:0] SAMPLE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] SAMPLE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [1:0]                   state_q, state_d;
    logic signed [ACC_W-1:0]      sum_q, sum_d, sum_nxt;
    logic signed [DATA_WIDTH-1:0] max_q, max_d, max_nxt;
    logic signed [DATA_WIDTH-1:0] min_q, min_d, min_nxt;
    logic [BATCH_LOG2-1:0]        cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0] mean_q, mean_d, mean_nxt;
    logic [DATA_WIDTH:0]          range_q, range_d, range_nxt;
    logic                         accept;
    logic                         last;

    // A start in ACCUM restarts the batch, so a sample in that same cycle
    // must not be folded into the fresh statistics.
    assign accept = (state_q == S_ACCUM) && in_valid && !start;
    assign last   = accept && (cnt_q == {BATCH_LOG2{1'b1}});

    // Candidate statistics including the current sample; used both for the
    // running update and for the result captured on the final accept.
    assign sum_nxt = sum_q + ACC_W'(in_data);
    assign max_nxt = (in_data > max_q) ? in_data : max_q;
    assign min_nxt = (in_data < min_q) ? in_data : min_q;

    // max >= min always holds once a sample has been seen, so the modular
    // difference at DATA_WIDTH+1 bits is the exact unsigned range.
    assign range_nxt = {max_nxt[DATA_WIDTH-1], max_nxt} - {min_nxt[DATA_WIDTH-1], min_nxt};

    // The upper DATA_WIDTH bits of the sum are exactly sum >>> BATCH_LOG2.
`ifdef BN_STAT_ROUND_EN
    // Adding half an LSB before the shift only carries into the kept bits
    // when bit BATCH_LOG2-1 is set, so the rounding reduces to adding that
    // bit. The result cannot exceed the largest sample, so it never wraps.
    assign mean_nxt = sum_nxt[ACC_W-1:BATCH_LOG2] + DATA_WIDTH'(sum_nxt[BATCH_LOG2-1]);
`else
    assign mean_nxt = sum_nxt[ACC_W-1:BATCH_LOG2];
`endif

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        mean_d  = mean_q;
        range_d = range_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    sum_d   = '0;
                    cnt_d   = '0;
                    max_d   = SAMPLE_MIN;
                    min_d   = SAMPLE_MAX;
                end
            end

            S_ACCUM: begin
                if (start) begin
                    sum_d = '0;
                    cnt_d = '0;
                    max_d = SAMPLE_MIN;
                    min_d = SAMPLE_MAX;
                end else if (accept) begin
                    sum_d = sum_nxt;
                    max_d = max_nxt;
                    min_d = min_nxt;
                    cnt_d = cnt_q + BATCH_LOG2'(1);
                    if (last) begin
                        mean_d  = mean_nxt;
                        range_d = range_nxt;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // start is deliberately ignored here; the result must be
                // drained before another batch can begin.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
            range_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
            mean_q  <= mean_d;
            range_q <= range_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign mean      = mean_q;
    assign range     = range_q;

endmodule
